// File: rtl/ps2_frame_rx_if.sv
// PS/2 receive bus: device-side lines in, received byte and strobes out.
interface ps2_frame_rx_if;
  logic       Ps2Clk;
  logic       Ps2Data;
  logic       LoadDato;
  logic [7:0] Dato;
  logic       FrameError;

  modport master (output Ps2Clk, Ps2Data, input LoadDato, Dato, FrameError);
  modport slave  (input Ps2Clk, Ps2Data, output LoadDato, Dato, FrameError);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: start, 8 data bits LSB first, odd parity, stop, with inter-edge timeout.
// Define PS2_PARITY_CHECK_EN to discard frames whose parity is wrong; otherwise parity is sampled and ignored.
//
// state  | meaning
// IDLE   | waiting for a start bit; timeout counter held at 0
// DATA   | shifting in 8 data bits
// PARITY | next falling edge carries the parity bit
// STOP   | next falling edge carries the stop bit; load or flag error
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic           Clock,
  input logic           Reset,
  ps2_frame_rx_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          parity_q;
  logic [CW-1:0] tcnt;
  logic [7:0]    dato_q;
  logic          load_q;
  logic          ferr_q;
  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic          parity_ok;

  assign fall = clk_prev & ~clk_s2;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shreg, parity_q};
`else
  // parity is still captured so the frame timing is identical; it never gates the load
  assign parity_ok = (^{shreg, parity_q}) | 1'b1;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      bitcnt   <= 3'd0;
      shreg    <= 8'h00;
      parity_q <= 1'b0;
      tcnt     <= '0;
      dato_q   <= 8'h00;
      load_q   <= 1'b0;
      ferr_q   <= 1'b0;
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= bus.Ps2Clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= bus.Ps2Data;
      dat_s2   <= dat_s1;
      load_q   <= 1'b0;
      ferr_q   <= 1'b0;

      if (state == IDLE) begin
        tcnt <= '0;
        if (fall && !dat_s2) begin
          state  <= DATA;
          bitcnt <= 3'd0;
        end
      end else if (fall) begin
        tcnt <= '0;
        case (state)
          DATA: begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_q <= dat_s2;
            state    <= STOP;
          end
          STOP: begin
            if (dat_s2 && parity_ok) begin
              dato_q <= shreg;
              load_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (tcnt == TC_LAST) begin
        // device stopped clocking mid-frame: abandon it
        state  <= IDLE;
        ferr_q <= 1'b1;
        tcnt   <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  assign bus.LoadDato   = load_q;
  assign bus.FrameError = ferr_q;
  assign bus.Dato       = dato_q;

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the Clock cycles allowed between Ps2Clk falling edges inside a frame.
REQ-002 The block SHALL have port Clock  input  1  system clock; all logic on its rising edge.
REQ-003 The block SHALL have port Reset  input  1  reset (Reset, synchronous, active-high; clock Clock).
REQ-004 The block SHALL have port Ps2Clk  input  1  PS/2 device clock, asynchronous to Clock.
REQ-005 The block SHALL have port Ps2Data  input  1  PS/2 device data, asynchronous to Clock.
REQ-006 The block SHALL have port LoadDato  output  1  one-cycle strobe: Dato holds a new valid byte.
REQ-007 The block SHALL have port Dato  output  8  last correctly received byte.
REQ-008 The block SHALL have port FrameError  output  1  one-cycle strobe: frame discarded.

Function
REQ-009 Ps2Clk and Ps2Data SHALL each pass through a 2-flop synchronizer before any use.
REQ-010 A falling edge SHALL be a cycle where synchronized Ps2Clk is 0 and its previous-cycle value was 1; all bit sampling SHALL use synchronized Ps2Data in that cycle.
REQ-011 The state machine SHALL have states IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: on falling edge with data 0 (start bit) go to DATA with bit count 0; with data 1, stay in IDLE and take no action.
REQ-013 DATA: on each falling edge shift the data bit in LSB first; after the 8th bit go to PARITY.
REQ-014 PARITY: on falling edge capture the parity bit and go to STOP.
REQ-015 STOP: on falling edge, if data is 1 and parity is accepted, load the shifted byte into Dato and pulse LoadDato; otherwise pulse FrameError; go to IDLE in both cases.
REQ-016 Parity SHALL be odd: the 8 data bits plus parity bit contain an odd number of ones.
REQ-017 LoadDato and FrameError SHALL be registered, high for exactly one Clock cycle, and never high in the same cycle.
REQ-018 LoadDato SHALL assert on the first Clock edge after the cycle in which the stop-bit falling edge is detected; Dato SHALL change in that same cycle.
REQ-019 Dato SHALL hold its value between strobes and SHALL be unchanged by any discarded frame.
REQ-020 A timeout counter SHALL clear on every falling edge and count while the state is not IDLE.
REQ-021 When the counter reaches TIMEOUT_CYCLES-1 outside IDLE, the block SHALL return to IDLE and pulse FrameError once.
REQ-022 The timeout counter SHALL be held at 0 in IDLE.
REQ-023 The counter SHALL be wide enough for TIMEOUT_CYCLES with no wrap-around.
REQ-024 A new frame SHALL be accepted starting with the first falling edge after returning to IDLE, whether from a good frame, an error, or a timeout.

Reset
REQ-025 On Reset=1 the block SHALL set state IDLE, bit count 0, shift register 0x00, timeout counter 0, Dato 0x00, LoadDato 0, FrameError 0, and synchronizer/edge flops 1.
REQ-026 Reset mid-frame SHALL discard the partial frame with no strobe; the next start bit after release begins a new frame.

Configuration
REQ-027 With macro PS2_PARITY_CHECK_EN defined, a parity mismatch SHALL cause FrameError and no load.
REQ-028 With PS2_PARITY_CHECK_EN undefined, the parity bit SHALL be sampled but ignored; only the stop bit gates LoadDato.

Verification
REQ-029 Frame 0x1C, parity 0, stop 1 (Ps2Clk 10 kHz, Clock 50 MHz) -> one LoadDato pulse, Dato=0x1C, FrameError stays 0.
REQ-030 Back-to-back frames 0xF0 then 0x1C -> two LoadDato pulses, Dato 0xF0 then 0x1C, with no lost frame.
REQ-031 Frame 0x1C with parity 1 -> PS2_PARITY_CHECK_EN defined: FrameError pulse, Dato unchanged; undefined: LoadDato pulse, Dato=0x1C.
REQ-032 Frame 0x55 with stop bit 0 -> FrameError pulse, no LoadDato, state returns to IDLE.
REQ-033 Start bit plus 4 data bits, then Ps2Clk held high, TIMEOUT_CYCLES=100 -> FrameError 100 cycles after the last edge; a following 0x29 frame gives Dato=0x29.
REQ-034 Reset pulsed after 5 data bits, then frame 0x3A -> no strobe from the partial frame; LoadDato pulse with Dato=0x3A.
